i2c_master_ctrl: RTL and testbench

Memory-mapped single-byte I2C master sitting directly downstream of the address decoder. It owns the CONTROL (0x40), STATUS (0x44) and DATA (0x48) registers. A CPU store with `i2c_en` high writes these registers; a load reads them back. Each launched transaction is START, 7-bit address + R/W, ACK, one data byte, ACK, STOP, driven onto an open-drain SDA and a master-only SCL.

---
 rtl/i2c_master_ctrl_pkg.sv | 33 +++
 rtl/i2c_master_ctrl_bit_timer.sv | 32 +++
 rtl/i2c_master_ctrl.sv | 143 ++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_master_ctrl_pkg.sv
// Shared definitions for the memory-mapped I2C master: register offsets,
// CONTROL/STATUS bit positions and the transaction FSM encoding.
package i2c_master_ctrl_pkg;

  localparam logic [7:0] CTRL_OFFSET   = 8'h40;
  localparam logic [7:0] STATUS_OFFSET = 8'h44;
  localparam logic [7:0] DATA_OFFSET   = 8'h48;

  localparam int CTRL_START    = 0;
  localparam int CTRL_RW       = 1;
  localparam int CTRL_ADDR_LSB = 2;
  localparam int CTRL_ADDR_MSB = 8;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_NACK = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_STOP
  } i2c_state_e;

  // Only address bits [3:2] select a register
  function automatic logic [1:0] reg_sel(input logic [7:0] offset);
    return offset[3:2];
  endfunction

endpackage

// File: rtl/i2c_master_ctrl_bit_timer.sv
// Quarter-bit phase generator: CLK_DIV system clocks per quarter, four
// quarters per bit; held at q0/count 0 whenever the master is idle.
module i2c_bit_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [1:0] quarter,
  output logic       quarter_end
);

  logic [7:0] cnt;

  assign quarter_end = en && (cnt == 8'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      quarter <= '0;
    end else if (!en) begin
      cnt     <= '0;
      quarter <= '0;
    end else if (quarter_end) begin
      cnt     <= '0;
      quarter <= quarter + 2'd1;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master with CONTROL/STATUS/DATA registers: one START,
// address+R/W, ACK, data byte, ACK, STOP sequence per launch.
module i2c_master_ctrl
  import i2c_master_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i2c_en,
  input  logic        mem_read,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        scl,
  output logic        sda_oe,
  input  logic        sda_i
);

  i2c_state_e state, next_state;
  logic [6:0] slave_addr;
  logic       rw;
  logic [7:0] tx_byte, rx_byte, shift_reg;
  logic [2:0] bit_cnt;
  logic       done, nack;
  logic [1:0] quarter;
  logic       quarter_end;
  logic       busy, wr_ok, launch, bit_end, sample_pt, scl_bit;
  logic [1:0] sel;
  logic [7:0] addr_byte;
  logic       unused_bits;

  assign unused_bits = ^{address[31:4], address[1:0], write_data[31:9]};

  assign busy      = (state != ST_IDLE);
  assign sel       = address[3:2];
  assign wr_ok     = i2c_en && !busy;
  assign launch    = wr_ok && (sel == reg_sel(CTRL_OFFSET)) && write_data[CTRL_START];
  assign bit_end   = quarter_end && (quarter == 2'd3);
  assign sample_pt = quarter_end && (quarter == 2'd1);
  assign scl_bit   = quarter[0] ^ quarter[1];
  assign addr_byte = {slave_addr, rw};

  i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk         (clk),
    .reset       (reset),
    .en          (busy),
    .quarter     (quarter),
    .quarter_end (quarter_end)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // An address NACK is already latched by the q1 sample, so ADDR_ACK can branch at q3
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (launch) next_state = ST_START;
      ST_START:    if (bit_end) next_state = ST_ADDR;
      ST_ADDR:     if (bit_end && bit_cnt == 3'd0) next_state = ST_ADDR_ACK;
      ST_ADDR_ACK: if (bit_end) next_state = nack ? ST_STOP : ST_DATA;
      ST_DATA:     if (bit_end && bit_cnt == 3'd0) next_state = ST_DATA_ACK;
      ST_DATA_ACK: if (bit_end) next_state = ST_STOP;
      ST_STOP:     if (bit_end) next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    scl    = 1'b1;
    sda_oe = 1'b0;
    case (state)
      ST_START:    sda_oe = quarter[1];
      ST_ADDR: begin
        scl    = scl_bit;
        sda_oe = !addr_byte[bit_cnt];
      end
      ST_ADDR_ACK: scl = scl_bit;
      ST_DATA: begin
        scl    = scl_bit;
        sda_oe = !rw && !tx_byte[bit_cnt];
      end
      ST_DATA_ACK: scl = scl_bit;
      ST_STOP: begin
        scl    = (quarter != 2'd0);
        sda_oe = !quarter[1];
      end
      default: ;
    endcase
  end

  // bit_cnt wraps 0 -> 7 on its own, so it is ready for the next byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slave_addr <= '0;
      rw         <= 1'b0;
      tx_byte    <= '0;
      rx_byte    <= '0;
      shift_reg  <= '0;
      bit_cnt    <= 3'd7;
      done       <= 1'b0;
      nack       <= 1'b0;
    end else begin
      if (wr_ok && sel == reg_sel(CTRL_OFFSET)) begin
        slave_addr <= write_data[CTRL_ADDR_MSB:CTRL_ADDR_LSB];
        rw         <= write_data[CTRL_RW];
      end
      if (launch) begin
        done <= 1'b0;
        nack <= 1'b0;
      end
      if (wr_ok && sel == reg_sel(DATA_OFFSET)) tx_byte <= write_data[7:0];
      if (bit_end && (state == ST_ADDR || state == ST_DATA)) bit_cnt <= bit_cnt - 3'd1;
      if (sample_pt) begin
        if (state == ST_ADDR_ACK && sda_i) nack <= 1'b1;
        if (state == ST_DATA && rw) shift_reg <= {shift_reg[6:0], sda_i};
        if (state == ST_DATA_ACK && !rw && sda_i) nack <= 1'b1;
      end
      if (bit_end && state == ST_DATA_ACK && rw) rx_byte <= shift_reg;
      if (bit_end && state == ST_STOP) done <= 1'b1;
    end
  end

  always_comb begin
    read_data = '0;
    if (mem_read) begin
      case (sel)
        reg_sel(CTRL_OFFSET):   read_data = {23'b0, slave_addr, rw, 1'b0};
        reg_sel(STATUS_OFFSET): begin
          read_data[STAT_BUSY] = busy;
          read_data[STAT_DONE] = done;
          read_data[STAT_NACK] = nack;
        end
        reg_sel(DATA_OFFSET):   read_data = {24'b0, rx_byte};
        default:                read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Self-checking bench: a bus-level slave/monitor decodes SCL/SDA and a
// transaction-level model predicts bits, status, length and readback.
module tb_i2c_master_ctrl;
  import i2c_master_ctrl_pkg::*;

  localparam int CLK_DIV = 4;
  localparam logic [31:0] A_CTRL   = {24'h0, CTRL_OFFSET};
  localparam logic [31:0] A_STATUS = {24'h0, STATUS_OFFSET};
  localparam logic [31:0] A_DATA   = {24'h0, DATA_OFFSET};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i2c_en = 1'b0;
  logic        mem_read = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        scl, sda_oe, sda_i;

  always #5 clk = ~clk;

  i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .i2c_en     (i2c_en),
    .mem_read   (mem_read),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .scl        (scl),
    .sda_oe     (sda_oe),
    .sda_i      (sda_i)
  );

  // open-drain bus: either side may pull low
  logic slave_pull = 1'b0;
  assign sda_i = ~(sda_oe | slave_pull);

  logic        slave_ack_addr = 1'b1;
  logic        slave_ack_data = 1'b1;
  logic [7:0]  slave_rd = 8'h00;
  logic        mon_prev_scl = 1'b1;
  logic        mon_prev_sda = 1'b1;
  logic        mon_rw = 1'b0;
  logic        mon_line;
  logic [31:0] bit_log = '0;
  int          rise_cnt = 0;
  int          start_cnt = 0;
  int          stop_cnt = 0;

  int          pass_count = 0;
  int          check_count = 0;
  logic [7:0]  tx_model = 8'h00;
  logic [7:0]  rx_model = 8'h00;
  logic [31:0] rd;

  // slave reacts to SCL falling edges, monitor logs SDA on SCL rising edges
  always @(negedge clk) begin
    mon_line = sda_i;
    if (mon_prev_scl && scl && mon_prev_sda && !mon_line) begin
      start_cnt++;
      bit_log = '0;
      rise_cnt = 0;
      slave_pull = 1'b0;
    end else if (mon_prev_scl && scl && !mon_prev_sda && mon_line) begin
      stop_cnt++;
    end else if (!mon_prev_scl && scl) begin
      bit_log = {bit_log[30:0], mon_line};
      rise_cnt++;
      if (rise_cnt == 8) mon_rw = mon_line;
    end else if (mon_prev_scl && !scl) begin
      slave_pull = 1'b0;
      if (rise_cnt == 8)
        slave_pull = slave_ack_addr;
      else if (rise_cnt >= 9 && rise_cnt <= 16 && mon_rw && slave_ack_addr)
        slave_pull = ~slave_rd[16 - rise_cnt];
      else if (rise_cnt == 17 && !mon_rw)
        slave_pull = slave_ack_data;
    end
    mon_prev_scl = scl;
    mon_prev_sda = ~(sda_oe | slave_pull);
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    i2c_en = 1'b1;
    address = a;
    write_data = d;
    @(negedge clk);
    i2c_en = 1'b0;
  endtask

  task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
    mem_read = 1'b1;
    address = a;
    #1 d = read_data;
    mem_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [6:0] a, input logic r, input logic [7:0] tx,
                                input bit wr_tx, input bit aa, input bit ad,
                                input logic [7:0] rb, input bit lockout);
    int cycles, s0, p0, exp_rises;
    logic exp_nack, dack;
    logic [7:0] dbyte;
    logic [31:0] st, exp_log;
    slave_ack_addr = aa;
    slave_ack_data = ad;
    slave_rd = rb;
    if (wr_tx) begin
      cpu_write(A_DATA, {24'h0, tx});
      tx_model = tx;
    end
    s0 = start_cnt;
    p0 = stop_cnt;
    cpu_write(A_CTRL, {23'b0, a, r, 1'b1});
    exp_nack = !aa || (!r && !ad);
    if (lockout) begin
      cpu_write(A_DATA, 32'hFF);
      cpu_write(A_CTRL, {23'b0, ~a, ~r, 1'b1});
      cpu_write(A_STATUS, 32'hFFFF_FFFF);
    end
    cycles = 0;
    st = 32'h1;
    for (int i = 0; i < 2000; i++) begin
      cpu_read(A_STATUS, st);
      if (!st[0]) break;
      cycles++;
    end
    check_output("busy_fall", {31'b0, st[0]}, 32'h0);
    if (!lockout) check_output("busy_len", cycles, (aa ? 80 : 44) * CLK_DIV);
    check_output("status", st, {29'b0, exp_nack, 1'b1, 1'b0});
    dbyte = r ? rb : tx_model;
    dack = r ? 1'b1 : !ad;
    if (aa) begin
      exp_log = {13'b0, a, r, 1'b0, dbyte, dack, 1'b0};
      exp_rises = 19;
    end else begin
      exp_log = {22'b0, a, r, 1'b1, 1'b0};
      exp_rises = 10;
    end
    if (r && aa) rx_model = rb;
    check_output("bus_bits", bit_log, exp_log);
    check_output("bus_rises", rise_cnt, exp_rises);
    check_output("start_seen", start_cnt - s0, 1);
    check_output("stop_seen", stop_cnt - p0, 1);
    cpu_read(A_DATA, rd);
    check_output("data_rd", rd, {24'h0, rx_model});
    cpu_read(A_CTRL, rd);
    check_output("ctrl_rd", rd, {23'b0, a, r, 1'b0});
    if (lockout) begin
      repeat (20) @(negedge clk);
      check_output("no_relaunch", start_cnt - s0, 1);
      cpu_read(A_STATUS, rd);
      check_output("status_idle", rd, {29'b0, exp_nack, 1'b1, 1'b0});
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired before completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_output("rst_scl", {31'b0, scl}, 32'h1);
    check_output("rst_sda_oe", {31'b0, sda_oe}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    cpu_read(A_CTRL, rd);
    check_output("rst_ctrl", rd, 32'h0);
    cpu_read(A_STATUS, rd);
    check_output("rst_status", rd, 32'h0);
    cpu_read(A_DATA, rd);
    check_output("rst_data", rd, 32'h0);

    $display("[TB] directed write 0x28 <- 0xA5");
    apply_stimulus(7'h28, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
    $display("[TB] directed read 0x28 -> 0x3C");
    apply_stimulus(7'h28, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0);
    $display("[TB] address NACK");
    apply_stimulus(7'h28, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    $display("[TB] busy lockout");
    apply_stimulus(7'h28, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1);
    apply_stimulus(7'h11, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    cpu_read(32'h4C, rd);
    check_output("decode_none", rd, 32'h0);
    address = A_CTRL;
    mem_read = 1'b0;
    #1 check_output("no_mem_read", read_data, 32'h0);
    @(negedge clk);

    $display("[TB] randomized transactions");
    for (int k = 0; k < 6; k++) begin
      apply_stimulus(7'($urandom), 1'($urandom), 8'($urandom), 1'($urandom),
                     $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                     8'($urandom), 1'b0);
    end

    $display("[TB] reset during address bit 3");
    slave_ack_addr = 1'b1;
    cpu_write(A_CTRL, 32'h0000_00A1);
    repeat (81) @(negedge clk);
    check_output("pre_rst_scl", {31'b0, scl}, 32'h0);
    check_output("pre_rst_sda_oe", {31'b0, sda_oe}, 32'h1);
    mem_read = 1'b1;
    address = A_STATUS;
    #1 check_output("pre_rst_status", read_data, 32'h1);
    #1 reset = 1'b1;
    #1;
    check_output("mid_rst_scl", {31'b0, scl}, 32'h1);
    check_output("mid_rst_sda_oe", {31'b0, sda_oe}, 32'h0);
    check_output("mid_rst_status", read_data, 32'h0);
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    rx_model = 8'h00;
    tx_model = 8'h00;
    @(negedge clk);
    cpu_read(A_CTRL, rd);
    check_output("post_rst_ctrl", rd, 32'h0);
    cpu_read(A_DATA, rd);
    check_output("post_rst_data", rd, 32'h0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
